// File: rtl/bitserial_alu_dp.sv
// Digit-serial RV32I-class ALU: DIGIT bits per clock over an XLEN-bit word, valid/ready on both sides.
// Define BSALU_COMPARE_EN to build SLT/SLTU; otherwise ops 8/9 decode as illegal.
module bitserial_alu_dp #(
  parameter int XLEN  = 32,
  parameter int DIGIT = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy,
  output logic [1:0]      dbg_state
);
  localparam int SW   = $clog2(XLEN);
  localparam int SW1  = SW + 1;
  localparam int LD   = $clog2(DIGIT);
  localparam int NMAX = XLEN / DIGIT;
  localparam int CW   = $clog2(NMAX + 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_ILL  = 4'hF;

  // Handshake: a transfer happens on any rising edge where valid && ready are both high;
  // in_ready is high only in IDLE, out_valid only in DONE, so each op costs one bubble.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
  state_t state_q, state_d;

  logic [XLEN-1:0] a_q, b_q, acc_q, res_q;
  logic [3:0]      op_q;
  logic            carry_q;
  logic [CW-1:0]   cnt_q;
  logic [SW:0]     shamt_q;

  logic accept, last;
  assign accept = in_valid && (state_q == S_IDLE);
  assign last   = (state_q == S_RUN) && (cnt_q == CW'(1));

  // Illegal codes collapse to OP_ILL at accept so the datapath only sees legal ops.
  logic [3:0]    op_dec;
  logic [SW:0]   s_in, n_shift;
  logic [CW-1:0] n_init;
  logic          sub_in, sub_q;

  always_comb begin
    op_dec = OP_ILL;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA: op_dec = op;
`ifdef BSALU_COMPARE_EN
      OP_SLT, OP_SLTU: op_dec = op;
`endif
      default: op_dec = OP_ILL;
    endcase
  end

  assign s_in    = {1'b0, b[SW-1:0]};
  assign n_shift = (s_in == '0) ? SW1'(1) : ((s_in + SW1'(DIGIT - 1)) >> LD);
  assign sub_in  = (op_dec == OP_SUB) || (op_dec == OP_SLT) || (op_dec == OP_SLTU);
  assign sub_q   = (op_q == OP_SUB) || (op_q == OP_SLT) || (op_q == OP_SLTU);

  always_comb begin
    case (op_dec)
      OP_SLL, OP_SRL, OP_SRA: n_init = CW'(n_shift);
      OP_ILL:                 n_init = CW'(1);
      default:                n_init = CW'(NMAX);
    endcase
  end

  logic [DIGIT-1:0] a_dig, b_dig, b_eff, dig_res;
  logic [DIGIT:0]   sum;
  logic [XLEN-1:0]  acc_nx, shifted, fin_res;
  logic [SW:0]      sh_step;

  assign a_dig = a_q[DIGIT-1:0];
  assign b_dig = b_q[DIGIT-1:0];
  assign b_eff = sub_q ? ~b_dig : b_dig;
  assign sum   = {1'b0, a_dig} + {1'b0, b_eff} + {{DIGIT{1'b0}}, carry_q};

  always_comb begin
    case (op_q)
      OP_AND:  dig_res = a_dig & b_dig;
      OP_OR:   dig_res = a_dig | b_dig;
      OP_XOR:  dig_res = a_dig ^ b_dig;
      default: dig_res = sum[DIGIT-1:0];
    endcase
  end

  // Result digits enter at the top and migrate down, so after N steps acc holds the word.
  assign acc_nx  = (acc_q >> DIGIT) | (XLEN'(dig_res) << (XLEN - DIGIT));
  assign sh_step = (shamt_q > SW1'(DIGIT)) ? SW1'(DIGIT) : shamt_q;

  always_comb begin
    case (op_q)
      OP_SLL:  shifted = acc_q << sh_step;
      OP_SRL:  shifted = acc_q >> sh_step;
      OP_SRA:  shifted = $unsigned($signed(acc_q) >>> sh_step);
      default: shifted = acc_q;
    endcase
  end

`ifdef BSALU_COMPARE_EN
  // On the last step the top digit is in the low lane, so its MSBs are the word's sign bits.
  logic a_msb, b_msb, d_msb, slt_bit, sltu_bit;
  assign a_msb    = a_dig[DIGIT-1];
  assign b_msb    = b_dig[DIGIT-1];
  assign d_msb    = sum[DIGIT-1];
  assign slt_bit  = d_msb ^ ((a_msb ^ b_msb) & (d_msb ^ a_msb));
  assign sltu_bit = ~sum[DIGIT];
`endif

  always_comb begin
    case (op_q)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: fin_res = acc_nx;
      OP_SLL, OP_SRL, OP_SRA:                fin_res = shifted;
`ifdef BSALU_COMPARE_EN
      OP_SLT:                                fin_res = XLEN'(slt_bit);
      OP_SLTU:                               fin_res = XLEN'(sltu_bit);
`endif
      default:                               fin_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      op_q    <= OP_ILL;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      shamt_q <= '0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      acc_q   <= a;
      op_q    <= op_dec;
      carry_q <= sub_in;
      cnt_q   <= n_init;
      shamt_q <= s_in;
    end else if (state_q == S_RUN) begin
      a_q     <= a_q >> DIGIT;
      b_q     <= b_q >> DIGIT;
      carry_q <= sum[DIGIT];
      cnt_q   <= cnt_q - CW'(1);
      shamt_q <= shamt_q - sh_step;
      if (op_q == OP_SLL || op_q == OP_SRL || op_q == OP_SRA) acc_q <= shifted;
      else acc_q <= acc_nx;
      if (last) res_q <= fin_res;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_RUN;
      S_RUN:   if (last) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    out_valid = (state_q == S_DONE);
    dbg_state = state_q;
  end

  assign result = res_q;
endmodule

// File: tb/tb_bitserial_alu_dp.sv
// Bench for bitserial_alu_dp: DIGIT=1 and DIGIT=4 instances run the same ops side by side.
module tb_bitserial_alu_dp;
  localparam int XLEN = 32;
`ifdef BSALU_COMPARE_EN
  localparam bit CMP = 1'b1;
`else
  localparam bit CMP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rstn;
  logic            in_valid, out_ready;
  logic [3:0]      op;
  logic [XLEN-1:0] a, b;
  logic            in_ready1, out_valid1, busy1;
  logic            in_ready4, out_valid4, busy4;
  logic [XLEN-1:0] result1, result4;
  logic [1:0]      st1, st4;

  always #5 clk = ~clk;

  bitserial_alu_dp #(.XLEN(XLEN), .DIGIT(1)) u_d1 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready1), .op(op), .a(a), .b(b),
    .out_valid(out_valid1), .out_ready(out_ready), .result(result1), .busy(busy1), .dbg_state(st1)
  );
  bitserial_alu_dp #(.XLEN(XLEN), .DIGIT(4)) u_d4 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready4), .op(op), .a(a), .b(b),
    .out_valid(out_valid4), .out_ready(out_ready), .result(result4), .busy(busy4), .dbg_state(st4)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [XLEN-1:0] exp_q1[$];
  logic [XLEN-1:0] exp_q4[$];

  typedef struct {
    logic [3:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] exp;
  } vec_t;
  vec_t vecs[16];

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int nref(input logic [3:0] o, input logic [XLEN-1:0] bb, input int dg);
    int s;
    s = int'(bb[4:0]);
    case (o)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4: return XLEN / dg;
      4'd5, 4'd6, 4'd7:             return (s == 0) ? 1 : (s + dg - 1) / dg;
      4'd8, 4'd9:                   return CMP ? XLEN / dg : 1;
      default:                      return 1;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] ref_alu(input logic [3:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
    case (o)
      4'd0: return x + y;
      4'd1: return x - y;
      4'd2: return x & y;
      4'd3: return x | y;
      4'd4: return x ^ y;
      4'd5: return x << y[4:0];
      4'd6: return x >> y[4:0];
      4'd7: return $unsigned($signed(x) >>> y[4:0]);
      4'd8: return (CMP && ($signed(x) < $signed(y))) ? 32'd1 : 32'd0;
      4'd9: return (CMP && (x < y)) ? 32'd1 : 32'd0;
      default: return '0;
    endcase
  endfunction

  task automatic check_reset_values(input string name);
    check({name, " out_valid"}, {30'b0, out_valid1, out_valid4}, 32'd0);
    check({name, " busy"},      {30'b0, busy1, busy4},           32'd0);
    check({name, " in_ready"},  {30'b0, in_ready1, in_ready4},   32'd3);
    check({name, " state"},     {28'b0, st1, st4},               32'd0);
    check({name, " result1"},   result1, 32'd0);
    check({name, " result4"},   result4, 32'd0);
  endtask

  // Drives one op, then follows both instances to completion checking latency and result.
  task automatic run_op(input logic [3:0] o, input logic [XLEN-1:0] aa, input logic [XLEN-1:0] bb,
                        input logic [XLEN-1:0] exp, input string name);
    int n1, n4, cyc;
    bit seen1, seen4;
    logic [XLEN-1:0] e;
    n1 = nref(o, bb, 1);
    n4 = nref(o, bb, 4);
    check({name, " ready"}, {31'b0, in_ready1 & in_ready4}, 32'd1);
    op = o; a = aa; b = bb; in_valid = 1'b1; out_ready = 1'b1;
    exp_q1.push_back(exp);
    exp_q4.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 4'($urandom_range(0, 15)); a = $urandom; b = $urandom;
    cyc = 0; seen1 = 1'b0; seen4 = 1'b0;
    while (!(seen1 && seen4) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (!seen4 && out_valid4) begin
        seen4 = 1'b1;
        e = exp_q4.pop_front();
        check({name, " lat4"}, 32'(cyc), 32'(n4));
        check({name, " res4"}, result4, e);
      end
      if (!seen1 && out_valid1) begin
        seen1 = 1'b1;
        e = exp_q1.pop_front();
        check({name, " lat1"}, 32'(cyc), 32'(n1));
        check({name, " res1"}, result1, e);
      end
    end
    if (!seen1) begin
      check({name, " timeout1"}, 32'd0, 32'd1);
      void'(exp_q1.pop_front());
    end
    if (!seen4) begin
      check({name, " timeout4"}, 32'd0, 32'd1);
      void'(exp_q4.pop_front());
    end
    @(posedge clk); #1;
    check({name, " idle"}, {30'b0, out_valid1, out_valid4}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    vecs[1]  = '{4'd1,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE};
    vecs[2]  = '{4'd4,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0};
    vecs[3]  = '{4'd7,  32'h8000_0000, 32'h0000_0009, 32'hFFC0_0000};
    vecs[4]  = '{4'd5,  32'h1234_5678, 32'h0000_0000, 32'h1234_5678};
    vecs[5]  = '{4'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
    vecs[6]  = '{4'd3,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0};
    vecs[7]  = '{4'd6,  32'h8000_0000, 32'h0000_001F, 32'h0000_0001};
    vecs[8]  = '{4'd5,  32'h0000_0001, 32'h0000_0023, 32'h0000_0008};
    vecs[9]  = '{4'd7,  32'h7FFF_FFF0, 32'h0000_0004, 32'h07FF_FFFF};
    vecs[10] = '{4'd8,  32'hFFFF_FFFF, 32'h0000_0001, CMP ? 32'd1 : 32'd0};
    vecs[11] = '{4'd9,  32'hFFFF_FFFF, 32'h0000_0001, 32'd0};
    vecs[12] = '{4'd8,  32'h8000_0000, 32'h7FFF_FFFF, CMP ? 32'd1 : 32'd0};
    vecs[13] = '{4'd9,  32'h0000_0001, 32'h0000_0002, CMP ? 32'd1 : 32'd0};
    vecs[14] = '{4'hF,  32'h0000_1234, 32'h0000_0005, 32'd0};
    vecs[15] = '{4'd1,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};

    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    #1;
    check_reset_values("reset");
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("v%0d", i));

    for (int i = 0; i < 12; i++) begin
      logic [3:0] ro;
      logic [XLEN-1:0] ra, rb;
      ro = 4'($urandom_range(0, 15)); ra = $urandom; rb = $urandom;
      run_op(ro, ra, rb, ref_alu(ro, ra, rb), $sformatf("r%0d", i));
    end

    // Stall: result must hold and no new request may be taken while DONE.
    begin
      int cyc;
      logic [XLEN-1:0] e1, e4;
      op = 4'd0; a = 32'd100; b = 32'd23; in_valid = 1'b1; out_ready = 1'b0;
      exp_q1.push_back(32'd123);
      exp_q4.push_back(32'd123);
      @(posedge clk); #1;
      op = 4'd2; a = $urandom; b = $urandom;
      cyc = 0;
      while (!(out_valid1 && out_valid4) && cyc < 100) begin
        @(posedge clk); #1;
        cyc++;
      end
      check("stall done", {30'b0, out_valid1, out_valid4}, 32'd3);
      e1 = exp_q1.pop_front();
      e4 = exp_q4.pop_front();
      for (int k = 0; k < 20; k++) begin
        @(posedge clk); #1;
        check("stall res1", result1, e1);
        check("stall res4", result4, e4);
        check("stall in_ready", {30'b0, in_ready1, in_ready4}, 32'd0);
        check("stall out_valid", {30'b0, out_valid1, out_valid4}, 32'd3);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("release in_ready", {30'b0, in_ready1, in_ready4}, 32'd3);
      check("release busy", {30'b0, busy1, busy4}, 32'd0);
      check("release out_valid", {30'b0, out_valid1, out_valid4}, 32'd0);
      in_valid = 1'b0;
      @(posedge clk); #1;
    end

    // Reset in RUN cycle 10 (DIGIT=1) / while DONE is stalled (DIGIT=4).
    op = 4'd0; a = 32'hFFFF_FFFF; b = 32'd1; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("pre-reset busy", {30'b0, busy1, busy4}, 32'd3);
    rstn = 1'b0;
    #1;
    check_reset_values("midrun reset");
    @(posedge clk); #1;
    rstn = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    check_reset_values("post reset");
    run_op(4'd0, 32'h0000_1234, 32'h0000_1111, 32'h0000_2345, "after reset");

    check("queue1 empty", 32'(exp_q1.size()), 32'd0);
    check("queue4 empty", 32'(exp_q4.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bitserial_alu_dp.md
# bitserial_alu_dp

Digit-serial RV32I-class ALU, the parametrised successor to the team's single-bit serial ALU: processes DIGIT bits per clock over an XLEN-bit word, trading area for latency. Sits between the operand-fetch stage and write-back of the bit-serial core and uses a valid/ready handshake on both sides so it can be stalled by write-back. Adds signed/unsigned compare and multi-bit shift steps over the previous block.

## Interface
- XLEN, 32: operand/result width; power of two, 8..64.
- DIGIT, 1: bits processed per cycle; power of two, 1..XLEN.
- clk  in  1  rising-edge clock.
- rstn  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept; high exactly when state is IDLE.
- op  in  4  operation code, sampled on accept.
- a  in  XLEN  operand A, sampled on accept.
- b  in  XLEN  operand B / shift amount, sampled on accept.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  result, stable while out_valid.
- busy  out  1  state is not IDLE.

## Operation
- States: IDLE -> RUN on in_valid&&in_ready; RUN -> DONE after N cycles; DONE -> IDLE on out_valid&&out_ready.
- op codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU; all others illegal.
- ADD/SUB/logic: LSB-first, DIGIT bits per RUN cycle, N = XLEN/DIGIT; SUB = A + ~B + 1 (carry register preset to 1). Results wrap modulo 2^XLEN; no overflow flag.
- Shifts: s = b[log2(XLEN)-1:0]; each RUN cycle shifts by min(DIGIT, remaining); N = max(1, ceil(s/DIGIT)); s=0 returns a unchanged. SRA replicates bit XLEN-1.
- SLT/SLTU: serial subtract as SUB, N = XLEN/DIGIT; SLTU = NOT final carry; SLT = sign(diff) XOR signed overflow. Result zero-extended 0/1.
- Illegal op: N = 1, result 0.
- Operands latched at accept; a/b/op may change afterwards without effect.
- result register written only on RUN->DONE transition; holds until next completion.

## Timing
- Reset values: out_valid 0, result 0, busy 0, in_ready 1, state IDLE, carry 0, counter 0.
- Accept at edge T; out_valid rises after edge T+N; RUN occupies cycles T+1..T+N.
- Total latency accept-to-out_valid = N cycles; e.g. ADD XLEN=32 DIGIT=1: 32; DIGIT=4: 8.
- out_valid held, result stable, while out_ready low (unlimited stall).
- Handshake at edge U: out_valid 0 and in_ready 1 from U+1; no same-cycle accept while DONE (one bubble per op).
- in_valid during RUN/DONE ignored; no request queued.
- rstn low mid-RUN or mid-DONE: immediate return to reset values; pending result discarded, never presented.

## Configuration
- BSALU_COMPARE_EN defined: ops 8 (SLT) and 9 (SLTU) implemented as above.
- Undefined: ops 8 and 9 decode as illegal (N=1, result 0); compare/overflow logic not synthesised.

## Test plan
- XLEN=32 DIGIT=1, ADD a=0xFFFF_FFFF b=1, out_ready=1 -> out_valid exactly 32 cycles after accept, result 0x0000_0000.
- DIGIT=4, SUB a=5 b=7 -> result 0xFFFF_FFFE after 8 cycles; XOR 0xF0F0_F0F0,0xFF00_FF00 -> 0x0FF0_0FF0.
- DIGIT=4, SRA a=0x8000_0000 b=9 -> N=3, result 0xFFC0_0000; SLL b=0 -> N=1, result = a.
- Hold out_ready=0 for 20 cycles after out_valid with in_valid=1 -> result stable, in_ready=0, no new accept; release -> in_ready 1 next cycle.
- BSALU_COMPARE_EN: SLT 0xFFFF_FFFF vs 1 -> 1; SLTU same -> 0; macro undefined -> op 8 returns 0 after 1 cycle.
- Assert rstn=0 at RUN cycle 10 of ADD -> outputs at reset values; next op completes with correct result, no stale output.
